aes128_enc_iter: RTL

//  Parametrised AES-128 encryptor that folds the ten rounds onto UNROLL combinational round slices.
//  The round key is expanded on the fly alongside the state.

---
 rtl/aes128_enc_iter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/aes128_enc_iter.sv
// AES-128 encryptor that folds the ten rounds onto UNROLL combinational round slices,
// expanding the round key on the fly, behind a valid/ready handshake on both sides.
module aes128_enc_iter #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    input  logic [127:0] k,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output logic         busy
);
    localparam int ITER = 10 / UNROLL;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes128_enc_iter: UNROLL must be 1, 2, 5 or 10");
    end

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[11'(2047 - 8 * int'(x)) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One full AES round plus the matching key-schedule step; returns {state, round key}.
    function automatic logic [255:0] round_step(input logic [127:0] st, input logic [127:0] rk,
                                                input logic [3:0] rnd);
        logic [31:0]  w [4];
        logic [31:0]  t;
        logic [7:0]   b [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] mc;
        logic [127:0] nk;
        for (int i = 0; i < 4; i++) w[i] = rk[127 - 32 * i -: 32];
        t = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])}
            ^ {rcon(rnd), 24'h0};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        nk = {w[0], w[1], w[2], w[3]};
        for (int i = 0; i < 16; i++) b[i] = sbox(st[127 - 8 * i -: 8]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) sr[4 * c + r] = b[4 * ((c + r) % 4) + r];
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4 * c];
            a1 = sr[4 * c + 1];
            a2 = sr[4 * c + 2];
            a3 = sr[4 * c + 3];
            if (rnd == 4'd10) begin
                mc[127 - 32 * c -: 32] = {a0, a1, a2, a3};
            end else begin
                mc[127 - 32 * c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                          a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                          a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                          xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return {mc ^ nk, nk};
    endfunction

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d, rk_q, rk_d, dout_q, dout_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] slice_st, slice_rk;
    logic [3:0]   slice_rnd;
    logic         last_iter;

    always_comb begin
        slice_st  = st_q;
        slice_rk  = rk_q;
        slice_rnd = rnd_q;
        for (int i = 0; i < UNROLL; i++) begin
            {slice_st, slice_rk} = round_step(slice_st, slice_rk, slice_rnd);
            slice_rnd = slice_rnd + 4'd1;
        end
    end

    assign last_iter = (rnd_q == 4'(11 - UNROLL));

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rk_d        = rk_q;
        rnd_d       = rnd_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        case (state_q)
            StIdle: in_ready = 1'b1;
            StRun: begin
                st_d  = slice_st;
                rk_d  = slice_rk;
                rnd_d = rnd_q + 4'(UNROLL);
                if (last_iter) begin
                    dout_d      = slice_st;
                    out_valid_d = 1'b1;
                    rnd_d       = 4'd0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                in_ready = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Shared load path: from IDLE, or from DONE on the retiring edge.
        if (in_valid && in_ready) begin
            st_d    = din ^ k;
            rk_d    = k;
            rnd_d   = 4'd1;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            st_q        <= '0;
            rk_q        <= '0;
            rnd_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            rnd_q       <= rnd_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign busy      = (state_q != StIdle);

endmodule
